acc_regfile: RTL and testbench

- Accelerator register file; the responder for the pivot controller's read port and the sink for its FPU write-back port.
- Serves read requests with a RAW scoreboard. Each register carries a count of FPU results still in flight, so a read never returns data that an outstanding FPU operation will overwrite.
- Provides a second, lower-priority CPU write/read port for loading operands and draining results.

---
 rtl/acc_pkg.sv | 13 +
 rtl/acc_scoreboard.sv | 61 ++++++
 rtl/acc_regfile.sv | 85 ++++++++
 tb/tb_acc_regfile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and sizing constants for the accelerator register file.
package acc_pkg;

  localparam int unsigned ACC_NREGS  = 32;
  localparam int unsigned ACC_DATA_W = 32;
  localparam int unsigned ACC_PEND_W = 2;

  typedef logic [ACC_DATA_W-1:0]        data_t;
  typedef logic [$clog2(ACC_NREGS)-1:0] reg_addr_t;
  typedef reg_addr_t                    acc_rf_addr_t;
  typedef logic [ACC_PEND_W-1:0]        pend_cnt_t;

endpackage

// File: rtl/acc_scoreboard.sv
// Per-register count of FPU results in flight; drives issue back-pressure,
// the read hazard view and the busy flag.
module acc_scoreboard
  import acc_pkg::*;
#(
  parameter int unsigned NREGS  = ACC_NREGS,
  parameter int unsigned PEND_W = ACC_PEND_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     iss_valid_i,
  input  logic [$clog2(NREGS)-1:0] iss_tag_i,
  input  logic                     wren_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  output logic                     iss_full_o,
  output logic [NREGS-1:0]         pend_o,
  output logic [NREGS-1:0]         dec_o,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] r_cnt [NREGS];
  logic [NREGS-1:0]  w_inc;
  logic [NREGS-1:0]  w_dec;

  // pend_o is the count after this cycle's write-back, so a read can be
  // released in the same cycle the last outstanding result arrives.
  always_comb begin
    w_inc      = '0;
    w_dec      = '0;
    pend_o     = '0;
    busy_o     = 1'b0;
    iss_full_o = (r_cnt[iss_tag_i] == CNT_MAX) && !(wren_i && (waddr_i == iss_tag_i));
    for (int unsigned n = 0; n < NREGS; n++) begin
      w_dec[n]  = wren_i && (waddr_i == AW'(n)) && (r_cnt[n] != '0);
      w_inc[n]  = iss_valid_i && (iss_tag_i == AW'(n)) && !iss_full_o;
      pend_o[n] = (r_cnt[n] - PEND_W'(w_dec[n])) != '0;
      busy_o    = busy_o | (r_cnt[n] != '0);
    end
  end

  assign dec_o = w_dec;

  always_ff @(posedge clk_i) begin
    for (int unsigned n = 0; n < NREGS; n++) begin
      if (rst_i) begin
        r_cnt[n] <= '0;
      end else if (w_inc[n] && !w_dec[n]) begin
        r_cnt[n] <= r_cnt[n] + 1'b1;
      end else if (w_dec[n] && !w_inc[n]) begin
        r_cnt[n] <= r_cnt[n] - 1'b1;
      end
    end
  end

  a_no_issue_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(iss_valid_i && iss_full_o));

endmodule

// File: rtl/acc_regfile.sv
// Accelerator register file: scoreboarded controller read port, FPU
// write-back sink and a lower-priority CPU load/drain port.
module acc_regfile
  import acc_pkg::*;
#(
  parameter int unsigned NREGS  = ACC_NREGS,
  parameter int unsigned DATA_W = ACC_DATA_W,
  parameter int unsigned PEND_W = ACC_PEND_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rreq_i,
  input  logic [$clog2(NREGS)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rvalid_o,
  input  logic                     iss_valid_i,
  input  logic [$clog2(NREGS)-1:0] iss_tag_i,
  output logic                     iss_full_o,
  input  logic                     wren_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     cpu_we_i,
  input  logic [$clog2(NREGS)-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0]        cpu_wdata_i,
  output logic                     cpu_wready_o,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     busy_o
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic [NREGS-1:0]  w_pend;
  logic [NREGS-1:0]  w_dec;
  logic              w_serve;
  logic [DATA_W-1:0] w_rd_data;

  acc_scoreboard #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .iss_valid_i (iss_valid_i),
    .iss_tag_i   (iss_tag_i),
    .wren_i      (wren_i),
    .waddr_i     (waddr_i),
    .iss_full_o  (iss_full_o),
    .pend_o      (w_pend),
    .dec_o       (w_dec),
    .busy_o      (busy_o)
  );

  // Bypass follows any write-back to the read address, stray or not.
  always_comb begin
    w_serve   = rreq_i && !r_rvalid && !w_pend[raddr_i];
    w_rd_data = (wren_i && (waddr_i == raddr_i)) ? wdata_i : r_mem[raddr_i];
  end

  assign cpu_wready_o = !wren_i;
  assign cpu_rdata_o  = r_mem[cpu_addr_i];
  assign rdata_o      = r_rdata;
  assign rvalid_o     = r_rvalid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < NREGS; n++) begin
        r_mem[n] <= '0;
      end
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (wren_i) begin
        r_mem[waddr_i] <= wdata_i;
      end else if (cpu_we_i) begin
        r_mem[cpu_addr_i] <= cpu_wdata_i;
      end
      r_rvalid <= w_serve;
      if (w_serve) begin
        r_rdata <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_acc_regfile.sv
// Bench for acc_regfile: directed scenarios plus randomized traffic, every
// cycle compared against an array-based reference model.
module tb_acc_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rreq;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        iss_valid;
  logic [4:0]  iss_tag;
  logic        iss_full;
  logic        wren;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wready;
  logic [31:0] cpu_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        armed = 1'b0;

  acc_regfile #(
    .NREGS  (32),
    .DATA_W (32),
    .PEND_W (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rreq_i       (rreq),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .rvalid_o     (rvalid),
    .iss_valid_i  (iss_valid),
    .iss_tag_i    (iss_tag),
    .iss_full_o   (iss_full),
    .wren_i       (wren),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_wready_o (cpu_wready),
    .cpu_rdata_o  (cpu_rdata),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_full();
    return (m_cnt[iss_tag] == 3) && !(wren && (waddr == iss_tag));
  endfunction

  function automatic logic m_busy();
    for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Compare all outputs with the model, then advance one clock edge.
  task automatic tick();
    int          ec;
    logic        serve;
    logic        f;
    logic        dec;
    logic [31:0] d;
    #1;
    if (armed) begin
      chk("iss_full", {31'b0, iss_full}, {31'b0, m_full()});
      chk("cpu_wready", {31'b0, cpu_wready}, {31'b0, !wren});
      chk("cpu_rdata", cpu_rdata, m_mem[cpu_addr]);
      chk("busy", {31'b0, busy}, {31'b0, m_busy()});
      chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      chk("rdata", rdata, m_rdata);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0;
        m_cnt[i] = 0;
      end
      m_rvalid = 1'b0;
      m_rdata  = '0;
      armed    = 1'b1;
    end else begin
      f     = m_full();
      dec   = wren && (m_cnt[waddr] != 0);
      ec    = m_cnt[raddr] - ((dec && (waddr == raddr)) ? 1 : 0);
      serve = rreq && !m_rvalid && (ec == 0);
      d     = (wren && (waddr == raddr)) ? wdata : m_mem[raddr];
      if (iss_valid && !f) m_cnt[iss_tag]++;
      if (dec) m_cnt[waddr]--;
      if (wren) m_mem[waddr] = wdata;
      else if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
      m_rvalid = serve;
      if (serve) m_rdata = d;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; rreq = 1'b0; raddr = '0; iss_valid = 1'b0; iss_tag = '0;
    wren = 1'b0; waddr = '0; wdata = '0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Random prior contents, then reset
    for (int i = 0; i < 10; i++) begin
      cpu_we = 1'b1; cpu_addr = 5'($urandom_range(31)); cpu_wdata = $urandom;
      tick();
    end
    cpu_we = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cpu_addr = 5'(i);
      #1;
      chk("rst_rdata", cpu_rdata, 32'h0);
      tick();
    end
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);

    // Hazard-free read of reg 5
    rreq = 1'b1; raddr = 5'd5;
    tick();
    chk("r5_rvalid", {31'b0, rvalid}, 32'h1);
    chk("r5_rdata", rdata, 32'h0);
    rreq = 1'b0;
    tick();

    // CPU load then read: exactly one pulse
    cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'h3F800000;
    tick();
    cpu_we = 1'b0;
    rreq = 1'b1; raddr = 5'd3;
    tick();
    chk("r3_rvalid", {31'b0, rvalid}, 32'h1);
    chk("r3_rdata", rdata, 32'h3F800000);
    tick();
    chk("r3_nopulse", {31'b0, rvalid}, 32'h0);
    rreq = 1'b0;
    tick();

    // RAW stall on tag 7 released by bypass
    iss_valid = 1'b1; iss_tag = 5'd7;
    tick();
    iss_valid = 1'b0;
    rreq = 1'b1; raddr = 5'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r7_stall", {31'b0, rvalid}, 32'h0);
    end
    wren = 1'b1; waddr = 5'd7; wdata = 32'h40000000;
    tick();
    wren = 1'b0; rreq = 1'b0;
    chk("r7_rvalid", {31'b0, rvalid}, 32'h1);
    chk("r7_rdata", rdata, 32'h40000000);
    chk("r7_busy", {31'b0, busy}, 32'h0);
    tick();

    // Fill tag 2 to the limit, drain with three write-backs
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_tag = 5'd2;
      tick();
    end
    iss_valid = 1'b0;
    #1;
    chk("t2_full", {31'b0, iss_full}, 32'h1);
    rreq = 1'b1; raddr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      wren = 1'b1; waddr = 5'd2; wdata = 32'h1000 + 32'(i);
      #1;
      chk("t2_full_wb", {31'b0, iss_full}, 32'h0);
      tick();
      chk("t2_rvalid", {31'b0, rvalid}, (i == 2) ? 32'h1 : 32'h0);
    end
    wren = 1'b0; rreq = 1'b0;
    chk("t2_rdata", rdata, 32'h1002);
    tick();

    // Simultaneous issue and write-back on reg 9
    iss_valid = 1'b1; iss_tag = 5'd9;
    tick();
    wren = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    iss_valid = 1'b0;
    chk("r9_busy", {31'b0, busy}, 32'h1);
    tick();
    wren = 1'b0;
    chk("r9_busy_clear", {31'b0, busy}, 32'h0);

    // CPU vs FPU write collision on reg 4
    cpu_we = 1'b1; cpu_addr = 5'd4; cpu_wdata = 32'hAAAA5555;
    wren = 1'b1; waddr = 5'd4; wdata = 32'h12345678;
    #1;
    chk("r4_wready", {31'b0, cpu_wready}, 32'h0);
    tick();
    wren = 1'b0;
    #1;
    chk("r4_fpu", cpu_rdata, 32'h12345678);
    chk("r4_wready1", {31'b0, cpu_wready}, 32'h1);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("r4_cpu", cpu_rdata, 32'hAAAA5555);

    // Reset while a read is stalled on a pending register
    iss_valid = 1'b1; iss_tag = 5'd11;
    tick();
    iss_valid = 1'b0;
    rreq = 1'b1; raddr = 5'd11;
    tick();
    chk("r11_stall", {31'b0, rvalid}, 32'h0);
    rst = 1'b1;
    tick();
    chk("r11_rst_busy", {31'b0, busy}, 32'h0);
    chk("r11_rst_rvalid", {31'b0, rvalid}, 32'h0);
    rst = 1'b0;
    tick();
    chk("r11_rvalid", {31'b0, rvalid}, 32'h1);
    chk("r11_rdata", rdata, 32'h0);
    rreq = 1'b0;

    // Randomized traffic on a narrow address window to provoke hazards
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(199) == 0);
      if (rreq && m_rvalid) rreq = 1'b0;
      else if (!rreq && ($urandom_range(2) == 0)) begin
        rreq = 1'b1; raddr = 5'($urandom_range(7));
      end
      wren  = ($urandom_range(2) == 0);
      waddr = 5'($urandom_range(7));
      wdata = $urandom;
      iss_tag = 5'($urandom_range(7));
      iss_valid = ($urandom_range(1) == 0) && !m_full();
      cpu_we = ($urandom_range(3) == 0);
      cpu_addr = 5'($urandom_range(7));
      cpu_wdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
